// File: rtl/eth_crc32_stream.sv
// Frame-aware streaming CRC-32 (IEEE 802.3, reflected) for the GMII MAC datapath.
// Absorbs DATA_W/8 bytes per beat; generates the FCS for TX or checks the residue on RX.
module eth_crc32_stream #(
  parameter int unsigned DATA_W        = 8,
  parameter logic [31:0] POLY          = 32'h04C11DB7,
  parameter logic [31:0] INIT          = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT       = 32'hFFFFFFFF,
  parameter logic [31:0] CHECK_RESIDUE = 32'h2144DF1C
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic                in_eof,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                mode_check,
  output logic                crc_valid,
  output logic [31:0]         crc_value,
  output logic                crc_ok,
  output logic [15:0]         frame_len,
  output logic                err_pulse
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(LANES + 1);

  typedef enum logic {ST_IDLE, ST_FRAME} state_e;

  // One byte step in normal (MSB-first) register form; bits enter LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ b[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        mode_q, mode_d;
  logic        valid_q, valid_d;
  logic [31:0] value_q, value_d;
  logic        ok_q, ok_d;
  logic [15:0] flen_q, flen_d;
  logic        err_q, err_d;

  logic [LANES-1:0] lane_en;
  logic [CNT_W-1:0] beat_bytes;
  logic             run;
  logic [31:0]      crc_next;
  logic [16:0]      len_sum;
  logic [15:0]      len_next;
  logic             mode_eff;
  logic [31:0]      result;

  // Beat datapath: only lanes below the lowest zero keep bit count on the eof beat.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    lane_en    = '1;
    beat_bytes = '0;
    run        = 1'b1;
    crc_next   = in_sof ? INIT : crc_q;
    for (int i = 0; i < LANES; i++) begin
      if (in_eof) run = run & in_keep[i];
      lane_en[i] = run;
    end
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        crc_next   = crc_byte(crc_next, in_data[8*i +: 8]);
        beat_bytes = beat_bytes + CNT_W'(1);
      end
    end
    len_sum  = {1'b0, (in_sof ? 16'h0 : len_q)} + 17'(beat_bytes);
    len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    mode_eff = in_sof ? mode_check : mode_q;
    result   = reflect32(crc_next) ^ XOR_OUT;
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    value_d = value_q;
    ok_d    = ok_q;
    flen_d  = flen_q;
    if (in_valid) begin
      if (in_sof) begin
        // A sof inside a frame aborts it; the new frame starts from this beat.
        err_d   = (state_q == ST_FRAME);
        crc_d   = crc_next;
        len_d   = len_next;
        mode_d  = mode_check;
        state_d = ST_FRAME;
      end else if (state_q == ST_FRAME) begin
        crc_d = crc_next;
        len_d = len_next;
      end else begin
        err_d = 1'b1;
      end
      if (in_eof && (in_sof || state_q == ST_FRAME)) begin
        valid_d = 1'b1;
        value_d = result;
        ok_d    = mode_eff && (result == CHECK_RESIDUE);
        flen_d  = len_next;
        crc_d   = INIT;
        state_d = ST_IDLE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
      len_q   <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      value_q <= '0;
      ok_q    <= 1'b0;
      flen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      value_q <= value_d;
      ok_q    <= ok_d;
      flen_q  <= flen_d;
      err_q   <= err_d;
    end
  end

  assign crc_valid = valid_q;
  assign crc_value = value_q;
  assign crc_ok    = ok_q;
  assign frame_len = flen_q;
  assign err_pulse = err_q;

endmodule
